fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader_pkg.sv | 9 +
 rtl/fifo_stream_reader.sv | 55 +++++
 tb/tb_fifo_stream_reader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg: buffer geometry and ring-pointer helper for the stream reader
package fifo_stream_reader_pkg;
  localparam int buf_depth = 3;
  localparam int ptr_w = $clog2(buf_depth);
  typedef logic [ptr_w-1:0] ptr_t;
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(buf_depth - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: turns a pop-then-data FIFO read port into a registered ready/valid stream
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [data_width-1:0] fifo_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output logic                  busy
);
  logic [data_width-1:0] r_mem [buf_depth];
  ptr_t                  r_head;
  ptr_t                  r_tail;
  logic [1:0]            r_count;
  logic                  r_inflight;
  logic                  w_xfer;
  logic [2:0]            w_used;
  // pop only when a slot is guaranteed for the returning word; gated by reset
  always_comb begin
    w_used     = {1'b0, r_count} + {2'b0, r_inflight};
    w_xfer     = out_valid && out_ready;
    fifo_rd_en = rst && !fifo_empty && (w_used < 3'(buf_depth));
    out_valid  = r_count != 2'd0;
    out_data   = r_mem[r_head];
    busy       = out_valid || r_inflight;
  end
  // buffer storage: capture the in-flight word at the tail
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < buf_depth; i++) r_mem[i] <= '0;
    end else if (r_inflight) begin
      r_mem[r_tail] <= fifo_dout;
    end
  end
  // pointers, occupancy and in-flight tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
      r_tail     <= r_inflight ? ptr_inc(r_tail) : r_tail;
      r_head     <= w_xfer ? ptr_inc(r_head) : r_head;
      r_count    <= r_count + 2'(r_inflight) - 2'(w_xfer);
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: randomized scoreboard bench with a behavioural upstream FIFO
module tb_fifo_stream_reader;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en, out_valid, busy;
  logic [7:0] out_data;
  int         n_cmp = 0, n_bad = 0, cyc = 0, first_v = -1, pops = 0;
  logic [7:0] fq[$], exq[$], rxq[$];
  int         rxc[$];
  bit         hold = 0, last_x = 0;
  logic [7:0] hold_d;
  logic [7:0] t1_exp [3] = '{8'h11, 8'h22, 8'h33};

  always #5 clk = ~clk;

  fifo_stream_reader #(.data_width(8)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fq.push_back(d);
    exq.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic tick();
    bit rd, x;
    logic [7:0] d;
    @(negedge clk);
    rd = fifo_rd_en;
    x  = out_valid && out_ready;
    d  = out_data;
    chk("rd_while_empty", int'(rd && fifo_empty), 0);
    if (hold) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_data", int'(out_data), int'(hold_d));
    end
    hold   = out_valid && !out_ready;
    hold_d = out_data;
    if (out_valid && first_v < 0) first_v = cyc;
    if (x) begin
      chk("stale_word", int'(exq.size() != 0), 1);
      if (exq.size() != 0) chk("order", int'(d), int'(exq.pop_front()));
      rxq.push_back(d);
      rxc.push_back(cyc);
    end
    if (rd) pops++;
    last_x = x;
    @(posedge clk);
    #1;
    if (rd && fq.size() > 0) fifo_dout = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    cyc++;
  endtask

  initial begin
    fifo_empty = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    chk("rst_data", int'(out_data), 0);
    fifo_empty = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;

    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    cyc = 0; first_v = -1; rxq.delete(); rxc.delete();
    repeat (6) tick();
    chk("t1_latency", first_v, 2);
    chk("t1_count", rxq.size(), 3);
    for (int i = 0; i < rxq.size() && i < 3; i++) begin
      chk("t1_data", int'(rxq[i]), int'(t1_exp[i]));
      chk("t1_cycle", rxc[i], 2 + i);
    end

    out_ready = 1'b0; pops = 0; rxq.delete();
    for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
    repeat (10) tick();
    chk("t2_pops", pops, 3);
    chk("t2_busy", int'(busy), 1);
    chk("t2_head", int'(out_data), 8'h40);
    out_ready = 1'b1;
    for (int k = 0; k < 60 && exq.size() > 0; k++) tick();
    chk("t2_drained", exq.size(), 0);
    chk("t2_count", rxq.size(), 10);

    begin
      int nxt = 0;
      rxq.delete();
      for (int k = 0; k < 3000 && rxq.size() < 50; k++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (nxt < 50 && $urandom_range(0, 2) != 0) begin
          push(8'(nxt));
          nxt++;
        end
        tick();
      end
      chk("t3_count", rxq.size(), 50);
      for (int i = 0; i < rxq.size(); i++) chk("t3_seq", int'(rxq[i]), i);
    end

    out_ready = 1'b1;
    repeat (4) tick();
    push(8'h77); rxq.delete(); last_x = 0;
    for (int k = 0; k < 20 && !last_x; k++) tick();
    chk("t4_xfer", rxq.size(), 1);
    @(negedge clk);
    chk("t4_valid", int'(out_valid), 0);
    chk("t4_busy", int'(busy), 0);
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    push(8'hA1); push(8'hA2); push(8'hA3);
    tick(); tick();
    chk("t5_pre_busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    chk("t5_valid", int'(out_valid), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_rd_en", int'(fifo_rd_en), 0);
    chk("t5_data", int'(out_data), 0);
    fq.delete(); exq.delete(); fifo_empty = 1'b1; hold = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1; rxq.delete();
    repeat (6) tick();
    chk("t5_no_stale", rxq.size(), 0);
    push(8'hB1); push(8'hB2);
    repeat (8) tick();
    chk("t5_post_count", rxq.size(), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
